picosoc_wb_master_bridge: RTL and testbench

Converts the PicoRV32 native memory interface (valid/ready, byte strobes) into Wishbone classic single-beat master cycles. It sits directly upstream of the Wishbone RAM slave and any other SoC Wishbone slaves, which all see its wb_* outputs. A per-cycle watchdog terminates transfers that receive no acknowledge, so a missing slave cannot hang the CPU. Bus faults are reported through sticky status outputs.

---
 rtl/picosoc_wb_master_bridge_if.sv | 34 +++
 rtl/picosoc_wb_master_bridge.sv | 150 +++++++++++++++
 tb/tb_picosoc_wb_master_bridge.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/picosoc_wb_master_bridge_if.sv
// Bus bundle between the PicoRV32 native memory port and the Wishbone
// master side of the bridge. The master modport is the bridge's view.
interface picosoc_wb_master_bridge_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata,
    output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata,
    input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/picosoc_wb_master_bridge.sv
// PicoRV32 native memory port to Wishbone classic single-beat master, with a
// per-transfer watchdog so an absent slave cannot hang the CPU.
module picosoc_wb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hFFFF_FFFF
) (
  input  logic                       wb_clk_i,
  input  logic                       wb_rst_i,
  picosoc_wb_master_bridge_if.master bus,
  input  logic                       err_clr_i,
  output logic                       bus_err_o,
  output logic [31:0]                err_addr_o,
  output logic [7:0]                 err_cnt_o
);
  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] wdog_q, wdog_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        we_q, we_d;
  logic        cyc_q, cyc_d;
  logic        rdy_q, rdy_d;
  logic [31:0] rdata_q, rdata_d;
  logic        berr_q, berr_d;
  logic [31:0] eaddr_q, eaddr_d;
  logic [7:0]  ecnt_q, ecnt_d;
  logic        fault;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    sel_d   = sel_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    rdy_d   = 1'b0;
    rdata_d = rdata_q;
    fault   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.mem_valid) begin
          adr_d   = bus.mem_addr;
          dat_d   = bus.mem_wdata;
          we_d    = |bus.mem_wstrb;
          sel_d   = (|bus.mem_wstrb) ? bus.mem_wstrb : 4'hF;
          cyc_d   = 1'b1;
          wdog_d  = 16'd0;
          state_d = S_BUS;
        end
      end
      // ack has priority over err, and both over watchdog expiry
      S_BUS: begin
        if (bus.wb_ack_i) begin
          rdata_d = bus.wb_dat_i;
          cyc_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_RESP;
        end else if (bus.wb_err_i || (wdog_q == WDOG_LAST)) begin
          rdata_d = ERR_RDATA;
          cyc_d   = 1'b0;
          rdy_d   = 1'b1;
          fault   = 1'b1;
          state_d = S_RESP;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // A fault in the same cycle as a clear leaves the status freshly set.
  always_comb begin
    berr_d  = berr_q;
    eaddr_d = eaddr_q;
    ecnt_d  = ecnt_q;
    if (err_clr_i) begin
      berr_d = 1'b0;
      ecnt_d = 8'd0;
    end
    if (fault) begin
      berr_d  = 1'b1;
      eaddr_d = adr_q;
      ecnt_d  = err_clr_i ? 8'd1 : sat_inc8(ecnt_q);
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= S_IDLE;
      wdog_q  <= 16'd0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      rdy_q   <= 1'b0;
      rdata_q <= 32'd0;
      berr_q  <= 1'b0;
      eaddr_q <= 32'd0;
      ecnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      rdy_q   <= rdy_d;
      rdata_q <= rdata_d;
      berr_q  <= berr_d;
      eaddr_q <= eaddr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  assign bus.mem_ready = rdy_q;
  assign bus.mem_rdata = rdata_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus_err_o     = berr_q;
  assign err_addr_o    = eaddr_q;
  assign err_cnt_o     = ecnt_q;

endmodule

// File: tb/tb_picosoc_wb_master_bridge.sv
// Bench for picosoc_wb_master_bridge: a reactive Wishbone slave plus a
// transaction-level reference model of latency, data and fault status.
module tb_picosoc_wb_master_bridge;
  localparam int          T      = 8;
  localparam logic [31:0] ERRD   = 32'hFFFF_FFFF;
  localparam int          M_ACK  = 0;
  localparam int          M_ERR  = 1;
  localparam int          M_NONE = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        err_clr = 1'b0;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;

  picosoc_wb_master_bridge_if bif();

  picosoc_wb_master_bridge #(.TIMEOUT_CYCLES(T), .ERR_RDATA(ERRD)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .bus       (bif),
    .err_clr_i (err_clr),
    .bus_err_o (bus_err),
    .err_addr_o(err_addr),
    .err_cnt_o (err_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] smem    [0:255];
  logic [31:0] ref_mem [0:255];
  int          smode = M_ACK;
  int          sws   = 0;
  int          scnt  = 0;

  logic        m_err  = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Slave terminates in the (sws+2)-th cycle of the strobe; driven mid-cycle.
  always @(negedge clk) begin
    if (bif.wb_cyc_o && bif.wb_stb_o) begin
      scnt = scnt + 1;
      bif.wb_ack_i = (smode == M_ACK) && (scnt == sws + 2);
      bif.wb_err_i = (smode == M_ERR) && (scnt == sws + 2);
      if (bif.wb_ack_i) begin
        bif.wb_dat_i = smem[bif.wb_adr_o[9:2]];
        if (bif.wb_we_o)
          for (int b = 0; b < 4; b++)
            if (bif.wb_sel_o[b]) smem[bif.wb_adr_o[9:2]][8*b +: 8] = bif.wb_dat_o[8*b +: 8];
      end else begin
        bif.wb_dat_i = $urandom;
      end
    end else begin
      scnt = 0;
      bif.wb_ack_i = 1'b0;
      bif.wb_err_i = 1'b0;
      bif.wb_dat_i = $urandom;
    end
  end

  task automatic check_status(input string tag);
    check({tag, "_bus_err"}, {31'd0, bus_err}, {31'd0, m_err});
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, 32'(m_cnt));
    check({tag, "_err_addr"}, err_addr, m_addr);
  endtask

  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int mode, input int ws,
                         input bit clr);
    int          term_at, exp_lat, exp_cyc, n, cyc_n, stb_n;
    bit          ok, done;
    logic [31:0] exp_rd, rd, adr1;
    logic [3:0]  sel1;
    logic        we1;
    logic [7:0]  ix;

    ix      = addr[9:2];
    term_at = ws + 2;
    ok      = (mode == M_ACK) && (term_at <= T);
    if (mode != M_NONE && term_at <= T) begin
      exp_lat = term_at + 1;
      exp_cyc = term_at;
    end else begin
      exp_lat = T + 1;
      exp_cyc = T;
    end
    exp_rd = ok ? ref_mem[ix] : ERRD;

    smode = mode;
    sws   = ws;
    @(negedge clk);
    bif.mem_valid = 1'b1;
    bif.mem_addr  = addr;
    bif.mem_wdata = wdata;
    bif.mem_wstrb = wstrb;
    err_clr       = clr;
    n = 0; cyc_n = 0; stb_n = 0; done = 0;
    rd = '0; adr1 = '0; sel1 = '0; we1 = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bif.wb_cyc_o) cyc_n++;
      if (bif.wb_stb_o) stb_n++;
      if (n == 1) begin
        adr1 = bif.wb_adr_o;
        sel1 = bif.wb_sel_o;
        we1  = bif.wb_we_o;
      end
      if (bif.mem_ready) begin
        done = 1;
        rd   = bif.mem_rdata;
      end
    end
    bif.mem_valid = 1'b0;
    err_clr       = 1'b0;

    check("latency", 32'(n), 32'(exp_lat));
    check("cyc_cycles", 32'(cyc_n), 32'(exp_cyc));
    check("stb_cycles", 32'(stb_n), 32'(exp_cyc));
    check("wb_adr", adr1, addr);
    check("wb_sel", {28'd0, sel1}, {28'd0, (wstrb != 4'd0) ? wstrb : 4'hF});
    check("wb_we", {31'd0, we1}, {31'd0, (wstrb != 4'd0)});
    if (wstrb == 4'd0 || !ok) check("mem_rdata", rd, exp_rd);

    if (ok && wstrb != 4'd0)
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) ref_mem[ix][8*b +: 8] = wdata[8*b +: 8];
    if (!ok) begin
      m_err  = 1'b1;
      m_addr = addr;
      m_cnt  = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
    end else if (clr) begin
      m_err = 1'b0;
      m_cnt = 0;
    end

    @(posedge clk); #1;
    check("ready_one_cycle", {31'd0, bif.mem_ready}, 32'd0);
    check("cyc_low_after", {31'd0, bif.wb_cyc_o}, 32'd0);
    check_status("status");
  endtask

  initial begin
    logic [31:0] a, d;
    logic [3:0]  s;
    bif.mem_valid = 1'b0;
    bif.mem_addr  = '0;
    bif.mem_wdata = '0;
    bif.mem_wstrb = '0;
    bif.wb_ack_i  = 1'b0;
    bif.wb_err_i  = 1'b0;
    bif.wb_dat_i  = '0;
    for (int i = 0; i < 256; i++) begin
      smem[i]    = $urandom;
      ref_mem[i] = smem[i];
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mem_ready", {31'd0, bif.mem_ready}, 32'd0);
    check("rst_mem_rdata", bif.mem_rdata, 32'd0);
    check("rst_wb_adr", bif.wb_adr_o, 32'd0);
    check("rst_wb_dat", bif.wb_dat_o, 32'd0);
    check("rst_sel_we_cyc_stb", {26'd0, bif.wb_sel_o, bif.wb_we_o, bif.wb_cyc_o},
          32'd0);
    check("rst_stb", {31'd0, bif.wb_stb_o}, 32'd0);
    check_status("rst");
    rst_n = 1'b1;

    // Directed read
    smem[8'h10] = 32'hCAFE_BABE;
    ref_mem[8'h10] = 32'hCAFE_BABE;
    do_xfer(32'h40, 32'h0, 4'h0, M_ACK, 0, 0);

    // Byte write then readback
    smem[8'h11] = 32'hA5A5_A5A5;
    ref_mem[8'h11] = 32'hA5A5_A5A5;
    do_xfer(32'h44, 32'h1122_3344, 4'b0100, M_ACK, 0, 0);
    do_xfer(32'h44, 32'h0, 4'h0, M_ACK, 0, 0);

    // Timeout with no slave response
    do_xfer(32'h1000, 32'h0, 4'h0, M_NONE, 0, 0);

    // Error termination two cycles after strobe, then clear pulse
    do_xfer(32'h200, 32'h0, 4'h0, M_ERR, 1, 0);
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    check_status("after_clr");

    // Ack on the final watchdog cycle, and one cycle too late
    do_xfer(32'h80, 32'h0, 4'h0, M_ACK, T - 2, 0);
    do_xfer(32'h84, 32'h0, 4'h0, M_ACK, T - 1, 0);

    // Clear held across a faulting transfer
    do_xfer(32'h300, 32'h0, 4'h0, M_ERR, 0, 1);

    // Random mix
    for (int k = 0; k < 60; k++) begin
      a = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      d = $urandom;
      s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      do_xfer(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 7)),
              ($urandom_range(0, 9) == 0));
    end

    // Saturation of the fault counter
    for (int k = 0; k < 300; k++)
      do_xfer({22'd0, 8'($urandom_range(0, 255)), 2'b00}, 32'h0, 4'h0, M_ERR, 0, 0);
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);

    // Asynchronous reset in the middle of a bus cycle
    smode = M_NONE;
    @(negedge clk);
    bif.mem_valid = 1'b1;
    bif.mem_addr  = 32'h0000_0300;
    bif.mem_wstrb = 4'h0;
    @(posedge clk); #1;
    check("midrst_cyc_before", {31'd0, bif.wb_cyc_o}, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("midrst_cyc", {31'd0, bif.wb_cyc_o}, 32'd0);
    check("midrst_stb", {31'd0, bif.wb_stb_o}, 32'd0);
    check("midrst_ready", {31'd0, bif.mem_ready}, 32'd0);
    bif.mem_valid = 1'b0;
    m_err  = 1'b0;
    m_cnt  = 0;
    m_addr = 32'd0;
    check_status("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_xfer(32'h48, 32'h0, 4'h0, M_ACK, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "time limit");
  end

endmodule
